// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared opcodes, FSM states and instruction layout for the
//               ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int OP_W       = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_REG_AW = 2;
    localparam int INSTR_W    = OP_W + 3*DEF_REG_AW + DEF_DATA_W;

    // Opcodes 0000-1001 go straight to the ALU; 1100-1111 are forwarded too.
    localparam logic [OP_W-1:0] OP_ALU0  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ALU1  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ALU2  = 4'b0010;
    localparam logic [OP_W-1:0] OP_ALU3  = 4'b0011;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0100;
    localparam logic [OP_W-1:0] OP_NEG   = 4'b0101;
    localparam logic [OP_W-1:0] OP_ALU6  = 4'b0110;
    localparam logic [OP_W-1:0] OP_ALU7  = 4'b0111;
    localparam logic [OP_W-1:0] OP_EQ    = 4'b1000;
    localparam logic [OP_W-1:0] OP_GT    = 4'b1001;
    localparam logic [OP_W-1:0] OP_LOADI = 4'b1010;
    localparam logic [OP_W-1:0] OP_OUT   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Field layout {op, dst, srcA, srcB, imm}, MSB first.
    function automatic int imm_lsb(input int data_w, input int reg_aw);
        imm_lsb = 0 * (data_w + reg_aw);
    endfunction

    function automatic int srcb_lsb(input int data_w, input int reg_aw);
        srcb_lsb = data_w + 0 * reg_aw;
    endfunction

    function automatic int srca_lsb(input int data_w, input int reg_aw);
        srca_lsb = data_w + reg_aw;
    endfunction

    function automatic int dst_lsb(input int data_w, input int reg_aw);
        dst_lsb = data_w + 2*reg_aw;
    endfunction

    function automatic int op_lsb(input int data_w, input int reg_aw);
        op_lsb = data_w + 3*reg_aw;
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : seq_regfile
// Description : 2^AW x DATA_W register file, two async read ports, one
//               synchronous write port, synchronous reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_regfile
    import seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NREG = 1 << AW;

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule : seq_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Three-cycle IDLE/EXEC/WB instruction sequencer that drives an
//               8-bit ALU and writes its result back to a small register file.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import seq_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int REG_AW  = DEF_REG_AW,
    localparam int INSTR_W = OP_W + 3*REG_AW + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_z,
    output logic               done,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid
);

    localparam int IMM_LSB  = imm_lsb(DATA_W, REG_AW);
    localparam int SRCB_LSB = srcb_lsb(DATA_W, REG_AW);
    localparam int SRCA_LSB = srca_lsb(DATA_W, REG_AW);
    localparam int DST_LSB  = dst_lsb(DATA_W, REG_AW);
    localparam int OP_LSB   = op_lsb(DATA_W, REG_AW);

    state_e              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic [OP_W-1:0]     ir_op;
    logic [REG_AW-1:0]   ir_dst, ir_srca, ir_srcb;
    logic [DATA_W-1:0]   ir_imm;
    logic [DATA_W-1:0]   rd_a, rd_b;
    logic                rf_we;
    logic                is_special;

    assign ir_op   = ir_q[OP_LSB   +: OP_W];
    assign ir_dst  = ir_q[DST_LSB  +: REG_AW];
    assign ir_srca = ir_q[SRCA_LSB +: REG_AW];
    assign ir_srcb = ir_q[SRCB_LSB +: REG_AW];
    assign ir_imm  = ir_q[IMM_LSB  +: DATA_W];

    assign is_special = (ir_op == OP_LOADI) || (ir_op == OP_OUT);

    seq_regfile #(
        .DATA_W (DATA_W),
        .AW     (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (rf_we),
        .waddr_i   (ir_dst),
        .wdata_i   (result_q),
        .raddr_a_i (ir_srca),
        .rdata_a_o (rd_a),
        .raddr_b_i (ir_srcb),
        .rdata_b_o (rd_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            result_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            result_q    <= result_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Reset gates the combinational outputs so an aborted instruction
    // shows neither done nor ALU activity in the reset cycle.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        result_d    = result_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        instr_ready = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;

        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ir_op == OP_LOADI) begin
                    result_d = ir_imm;
                end else if (ir_op == OP_OUT) begin
                    result_d = rd_a;
                end else begin
                    result_d = alu_z;
                end
                if (!is_special && !reset) begin
                    alu_op = ir_op;
                    alu_a  = rd_a;
                    alu_b  = rd_b;
                end
                state_d = WB;
            end
            WB: begin
                done = !reset;
                if (ir_op == OP_OUT) begin
                    out_data_d  = result_q;
                    out_valid_d = 1'b1;
                end else begin
                    rf_we = !reset;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a small
//               behavioural ALU closing the operand/result loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [3:0] T_ADD   = 4'b0100;
    localparam logic [3:0] T_NEG   = 4'b0101;
    localparam logic [3:0] T_EQ    = 4'b1000;
    localparam logic [3:0] T_GT    = 4'b1001;
    localparam logic [3:0] T_LOADI = 4'b1010;
    localparam logic [3:0] T_OUT   = 4'b1011;
    localparam logic [3:0] T_X14   = 4'b1110;

    logic        clk;
    logic        reset;
    logic [17:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_z;
    logic        done;
    logic [7:0]  out_data;
    logic        out_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] ex_op;
    logic [7:0] ex_a, ex_b, last_out;
    logic       ex_ready, ex_done, wb_done, wb_ready, wb_ov, id_ov;
    logic [8:0] rdy_seq, done_seq;

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_z       (alu_z),
        .done        (done),
        .out_data    (out_data),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: only the operations exercised here; everything else yields 0.
    always_comb begin
        case (alu_op)
            T_ADD:   alu_z = alu_a + alu_b;
            T_NEG:   alu_z = 8'd0 - alu_a;
            T_EQ:    alu_z = (alu_a == alu_b) ? 8'd1 : 8'd0;
            T_GT:    alu_z = (alu_a > alu_b) ? 8'd1 : 8'd0;
            default: alu_z = 8'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one instruction from IDLE and captures observations of each phase.
    task automatic run(input logic [3:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm);
        int t;
        instr       = {op, dst, sa, sb, imm};
        instr_valid = 1'b1;
        t = 0;
        while (!instr_ready && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ex_op = alu_op; ex_a = alu_a; ex_b = alu_b; ex_ready = instr_ready; ex_done = done;
        @(posedge clk); #1;
        wb_done = done; wb_ready = instr_ready; wb_ov = out_valid;
        @(posedge clk); #1;
        id_ov = out_valid; last_out = out_data;
    endtask

    task automatic out_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
        run(T_OUT, 2'd0, r, 2'd0, 8'h00);
        chk(tag, 32'(last_out), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; instr = '0; instr_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready",  32'(instr_ready), 32'd1);
        chk("rst_done",   32'(done),        32'd0);
        chk("rst_ov",     32'(out_valid),   32'd0);
        chk("rst_out",    32'(out_data),    32'h00);
        chk("rst_aluop",  32'(alu_op),      32'h0);
        chk("rst_alu_ab", {alu_a, alu_b},   32'h0);
        out_reg("rst_r2", 2'd2, 8'h00);

        // Basic flow: LOADI, LOADI, ADD, OUT
        run(T_LOADI, 2'd1, 2'd0, 2'd0, 8'h05);
        chk("loadi_alu", {ex_op, ex_a, ex_b}, 32'h0);
        run(T_LOADI, 2'd2, 2'd0, 2'd0, 8'h03);
        run(T_ADD, 2'd0, 2'd1, 2'd2, 8'h00);
        chk("add_op",     32'(ex_op),    32'h4);
        chk("add_a",      32'(ex_a),     32'h05);
        chk("add_b",      32'(ex_b),     32'h03);
        chk("exec_ready", 32'(ex_ready), 32'd0);
        chk("exec_done",  32'(ex_done),  32'd0);
        chk("wb_done",    32'(wb_done),  32'd1);
        chk("wb_ready",   32'(wb_ready), 32'd0);
        run(T_OUT, 2'd0, 2'd0, 2'd0, 8'h00);
        chk("out_wb_ov",  32'(wb_ov),    32'd0);
        chk("out_ov",     32'(id_ov),    32'd1);
        chk("out_data",   32'(last_out), 32'h08);
        @(posedge clk); #1;
        chk("out_pulse1", 32'(out_valid), 32'd0);

        // Back-to-back with instr_valid held high
        instr = {T_LOADI, 2'd1, 2'd0, 2'd0, 8'h11};
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rdy_seq[8-i]  = instr_ready;
            done_seq[8-i] = done;
            if (i == 1) instr = {T_LOADI, 2'd2, 2'd0, 2'd0, 8'h22};
            if (i == 4) instr = {T_LOADI, 2'd3, 2'd0, 2'd0, 8'h33};
            if (i == 7) instr_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b_ready", 32'(rdy_seq),  32'b100100100);
        chk("b2b_done",  32'(done_seq), 32'b001001001);
        out_reg("b2b_r1", 2'd1, 8'h11);
        out_reg("b2b_r2", 2'd2, 8'h22);
        out_reg("b2b_r3", 2'd3, 8'h33);

        // Wrap-around and dst==src
        run(T_LOADI, 2'd1, 2'd0, 2'd0, 8'hFF);
        run(T_LOADI, 2'd2, 2'd0, 2'd0, 8'h01);
        run(T_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
        out_reg("wrap_r3", 2'd3, 8'h00);
        run(T_NEG, 2'd0, 2'd1, 2'd0, 8'h00);
        out_reg("neg_r0", 2'd0, 8'h01);
        run(T_ADD, 2'd1, 2'd1, 2'd2, 8'h00);
        out_reg("dstsrc_r1", 2'd1, 8'h00);

        // Unsigned compare
        run(T_LOADI, 2'd1, 2'd0, 2'd0, 8'h80);
        run(T_LOADI, 2'd2, 2'd0, 2'd0, 8'h7F);
        run(T_GT, 2'd0, 2'd1, 2'd2, 8'h00);
        out_reg("gt_unsigned", 2'd0, 8'h01);
        run(T_EQ, 2'd0, 2'd1, 2'd2, 8'h00);
        out_reg("eq_diff", 2'd0, 8'h00);
        run(T_EQ, 2'd0, 2'd1, 2'd1, 8'h00);
        out_reg("eq_same", 2'd0, 8'h01);

        // Reset during EXEC aborts the instruction
        run(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h5A);
        instr = {T_LOADI, 2'd3, 2'd0, 2'd0, 8'hAA};
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        reset = 1'b1;
        chk("rst_exec_done", 32'(done), 32'd0);
        chk("rst_exec_alu",  32'(alu_op), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_done", 32'(done),      32'd0);
        chk("rst_mid_ov",   32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_ready", 32'(instr_ready), 32'd1);
        chk("rst_mid_done2", 32'(done),        32'd0);
        out_reg("rst_mid_r3", 2'd3, 8'h00);
        out_reg("rst_mid_r0", 2'd0, 8'h00);

        // Opcode 1110 is forwarded; the ALU returns 0
        run(T_LOADI, 2'd1, 2'd0, 2'd0, 8'h12);
        run(T_X14, 2'd1, 2'd1, 2'd1, 8'h00);
        chk("x14_op",   32'(ex_op),   32'hE);
        chk("x14_a",    32'(ex_a),    32'h12);
        chk("x14_done", 32'(wb_done), 32'd1);
        out_reg("x14_r1", 2'd1, 8'h00);

        // Idle: ALU ports stay quiet
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_alu", {alu_op, alu_a, alu_b}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_sequencer
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control/datapath stage directly upstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and holds a small register file.
- Drives the ALU's operation and operand inputs, captures its combinational result, and writes that result back to a destination register.
- Also supports load-immediate and output instructions, so the ALU can be exercised by a stream of instructions instead of raw operands.

Parameters:
- DATA_W, 8, datapath width; fixed at 8 to match the ALU.
- REG_AW, 2, register address width; 2^REG_AW registers (R0..R3).
- Derived, not a parameter: INSTR_W = 4 + 3*REG_AW + DATA_W (18 with defaults).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  INSTR_W  instruction, fields {op[3:0], dst, srcA, srcB, imm[7:0]}, MSB first.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  sequencer can accept an instruction.
- alu_op  out  4  operation code to ALU.
- alu_a  out  DATA_W  operand A to ALU.
- alu_b  out  DATA_W  operand B to ALU.
- alu_z  in  DATA_W  ALU combinational result.
- done  out  1  one-cycle pulse when an instruction retires.
- out_data  out  DATA_W  value captured by the last OUT instruction.
- out_valid  out  1  one-cycle pulse when out_data updates.

Behaviour:
- Reset (synchronous, active-high; one clock with reset=1 is sufficient):
  - state=IDLE; R0..R3=0; IR=0; result register=0; out_data=0.
  - done=0, out_valid=0, alu_op=0000, alu_a=0, alu_b=0; instr_ready=1 from the first cycle after reset deasserts.
- States: IDLE -> EXEC -> WB -> IDLE. Every instruction takes exactly 3 cycles.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1, latch instr into IR and go to EXEC.
  - If instr_valid=0, stay in IDLE.
- EXEC:
  - instr_ready=0.
  - For IR.op 0000-1001 and 1100-1111: alu_op=IR.op, alu_a=R[srcA], alu_b=R[srcB]; result register <= alu_z at the clock edge.
  - LOADI (1010): alu_op=0000, alu_a=0, alu_b=0; result register <= imm.
  - OUT (1011): alu_op=0000, alu_a=0, alu_b=0; result register <= R[srcA].
- WB:
  - instr_ready=0; done=1 for this cycle only.
  - Non-OUT ops: R[dst] <= result register at the end of WB.
  - OUT: no register write; out_data <= result register; out_valid=1 in the cycle after WB (registered pulse), while done is asserted in WB.
  - Always go to IDLE.
- Outside EXEC: alu_op=0000, alu_a=0, alu_b=0.
- Latency: an instruction accepted at edge N produces its operands on the ALU ports in cycle N+1 and done in cycle N+2. The register write is visible from cycle N+3. Peak throughput is 1 instruction per 3 cycles.
- Hazards: dst==srcA or dst==srcB is always safe; reads occur in EXEC, before the WB write.
- Arithmetic: all in modulo 2^8 and performed by the ALU; the sequencer does no arithmetic. Compares are unsigned. Opcodes 1100-1111 are forwarded to the ALU, so dst receives 0.
- Handshake:
  - instr_valid asserted while instr_ready=0 is ignored; the upstream source must hold instr stable until it is accepted.
  - instr_ready does not depend combinationally on instr_valid.
- Reset mid-operation (in EXEC or WB): the instruction is aborted with no register write, no done and no out_valid, and the block returns to the reset state.

Decomposition:
- Shared package seq_pkg:
  - ALU opcode constants 0000-1001, OP_LOADI=1010, OP_OUT=1011.
  - State enum {IDLE, EXEC, WB}.
  - Instruction field offsets/widths and INSTR_W.
- One sub-module, seq_regfile: 4x8 registers, two combinational read ports, one synchronous write port, synchronous reset to 0.

Test Plan:
- LOADI R1,0x05; LOADI R2,0x03; ADD(0100) R0=R1+R2; OUT R0 -> in ADD's EXEC cycle alu_op=0100, alu_a=0x05, alu_b=0x03; out_data=0x08 with a single out_valid pulse.
- instr_valid held high across 3 back-to-back instructions -> each accepted exactly 3 cycles apart; instr_ready low in EXEC/WB; done exactly 2 cycles after each accept.
- LOADI R1,0xFF; LOADI R2,0x01; ADD R3=R1+R2 -> R3=0x00 (wrap). NEG(0101) R0=-R1 -> R0=0x01. ADD R1=R1+R2 -> R1=0x00 (dst==src safe).
- R1=0x80, R2=0x7F: GT(1001) R0 -> 0x01 (unsigned). EQ(1000) R0 -> 0x00. EQ R0=R1,R1 -> 0x01.
- Accept LOADI R3,0xAA; assert reset during EXEC -> R3 stays 0x00, no done, no out_valid, instr_ready=1 the cycle after reset drops.
- Opcode 1110 with R1=0x12 and dst=R1 -> R1 becomes 0x00 and done pulses. While idle (no valid), alu_op/alu_a/alu_b stay 0.
